// File: rtl/mem_responder_if.sv
// Memory handshake bundle between a CPU-side initiator and a memory-side responder.
// Signals:
//   mem_read / mem_write     request strobes, held by the initiator until mem_resp
//   mem_byte_enable [3:0]    write byte lanes, bit i selects wdata[8i+7:8i]
//   mem_address [31:0]       byte address, bits [1:0] ignored by the responder
//   mem_wdata [31:0]         write data
//   mem_resp                 one-cycle completion pulse
//   mem_rdata [31:0]         read data, valid in the mem_resp cycle
//   mem_err                  error flag, only together with mem_resp
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        mem_err;

  // Initiator (CPU) side
  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata, mem_err
  );

  // Responder (memory) side
  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: a word-addressed on-chip RAM that answers each request
// on the memory handshake after a fixed LATENCY (1..15) cycles.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset (RAM contents are not reset)
//   bus   mem_responder_if.slave: request in, mem_resp/mem_rdata/mem_err out
// Parameters:
//   ADDR_WIDTH  log2 of RAM depth in 32-bit words (must be < 30)
//   LATENCY     cycles from request acceptance to mem_resp, 1..15
module mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 3
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;

  // Request latched at acceptance
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    oob_q;
  logic                    rd_q;
  logic                    wr_q;
  logic [BE_W-1:0]         be_q;
  logic [DATA_W-1:0]       wdata_q;

  // Registered outputs
  logic                    resp_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    err_q;

  logic [DATA_W-1:0]       ram [DEPTH];

  // Address decode of the live request
  logic                    req_c;
  logic [ADDR_WIDTH-1:0]   in_idx_c;
  logic                    in_oob_c;
  logic                    unused_addr_c;

  assign req_c         = bus.mem_read | bus.mem_write;
  assign in_idx_c      = bus.mem_address[ADDR_WIDTH+1:2];
  assign in_oob_c      = |bus.mem_address[31:ADDR_WIDTH+2];
  assign unused_addr_c = ^bus.mem_address[1:0];

  // With LATENCY==1 the RESP entry coincides with acceptance, so the operands
  // come straight from the bus in IDLE and from the latches otherwise.
  logic                    cur_sel_bus_c;
  logic [ADDR_WIDTH-1:0]   cur_idx_c;
  logic                    cur_oob_c;
  logic                    cur_rd_c;
  logic                    cur_wr_c;
  logic [BE_W-1:0]         cur_be_c;
  logic [DATA_W-1:0]       cur_wdata_c;

  assign cur_sel_bus_c = (state == IDLE);
  assign cur_idx_c     = cur_sel_bus_c ? in_idx_c            : idx_q;
  assign cur_oob_c     = cur_sel_bus_c ? in_oob_c            : oob_q;
  assign cur_rd_c      = cur_sel_bus_c ? bus.mem_read        : rd_q;
  assign cur_wr_c      = cur_sel_bus_c ? bus.mem_write       : wr_q;
  assign cur_be_c      = cur_sel_bus_c ? bus.mem_byte_enable : be_q;
  assign cur_wdata_c   = cur_sel_bus_c ? bus.mem_wdata       : wdata_q;

  // Edge that enters RESP: completion, read capture and write commit happen here
  logic enter_resp_c;
  logic ram_we_c;

  always_comb begin
    enter_resp_c = 1'b0;
    if (state == IDLE && req_c && LATENCY <= 1)
      enter_resp_c = 1'b1;
    else if (state == WAIT && cnt == CNT_W'(2))
      enter_resp_c = 1'b1;
  end

  // Writes are dropped when out of range or paired with a read; rst gates the
  // commit so a request held during reset never reaches the RAM.
  assign ram_we_c = rst & enter_resp_c & cur_wr_c & ~cur_rd_c & ~cur_oob_c
                    & (|cur_be_c);

  // Control FSM with registered response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      oob_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      err_q  <= 1'b0;

      case (state)
        IDLE: begin
          if (req_c) begin
            idx_q   <= in_idx_c;
            oob_q   <= in_oob_c;
            rd_q    <= bus.mem_read;
            wr_q    <= bus.mem_write;
            be_q    <= bus.mem_byte_enable;
            wdata_q <= bus.mem_wdata;
            cnt     <= CNT_W'(LATENCY);
            state   <= (LATENCY > 1) ? WAIT : RESP;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(2))
            state <= RESP;
        end
        RESP: begin
          // The still-held request is deliberately not re-taken here.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (enter_resp_c) begin
        resp_q <= 1'b1;
        err_q  <= cur_oob_c | (cur_rd_c & cur_wr_c);
        if (cur_rd_c)
          rdata_q <= cur_oob_c ? '0 : ram[cur_idx_c];
      end
    end
  end

  // Byte-lane RAM write, no reset on storage
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (cur_be_c[b])
          ram[cur_idx_c][8*b +: 8] <= cur_wdata_c[8*b +: 8];
      end
    end
  end

  assign bus.mem_resp  = resp_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.mem_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (ADDR_WIDTH=10, LATENCY=3).
module tb_mem_responder;

  localparam int unsigned LAT = 3;

  logic clk;
  logic rst;

  mem_responder_if bus ();

  mem_responder #(
    .ADDR_WIDTH (10),
    .LATENCY    (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  // Issue one request at the current time (caller is at a negedge), hold it until
  // mem_resp, then drop it. lat counts edges from the accepting edge (1) to resp.
  task automatic do_req(input logic rd, input logic wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err);
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_byte_enable = be;
    bus.mem_address     = addr;
    bus.mem_wdata       = wd;
    lat   = 0;
    rdata = 32'h0;
    err   = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (bus.mem_resp) begin
        lat   = i;
        rdata = bus.mem_rdata;
        err   = bus.mem_err;
      end
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(posedge clk); #1;
    check("single_pulse", 32'(bus.mem_resp), 32'h0);
  endtask

  vec_t vecs [17];
  int          lat;
  logic [31:0] rdata;
  logic        err;

  initial begin
    //            rd    wr    be       addr          wdata         exp_rdata     err
    vecs[0]  = '{1'b0, 1'b1, 4'hF,    32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'b0010, 32'h0000_0010, 32'h0000_1200, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'hDEAD_12EF, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'hF,    32'h0000_0000, 32'h1111_1111, 32'hDEAD_12EF, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'h0,    32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 4'hF,    32'h0000_1000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 4'h0,    32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 4'hF,    32'h0000_0010, 32'h0000_0000, 32'hDEAD_12EF, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 4'h0,    32'h0000_0010, 32'h0,         32'hDEAD_12EF, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'h0,    32'h0000_0010, 32'hAAAA_AAAA, 32'hDEAD_12EF, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 4'h0,    32'h0000_0013, 32'h0,         32'hDEAD_12EF, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'hF,    32'h0000_0FFC, 32'hCAFE_F00D, 32'hDEAD_12EF, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 4'h0,    32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 4'b1001, 32'h0000_0FFC, 32'h5566_7788, 32'hCAFE_F00D, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 4'h0,    32'h0000_0FFC, 32'h0,         32'h55FE_F088, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 4'h0,    32'h8000_0010, 32'h0,         32'h0000_0000, 1'b1};

    // Reset held with a read pending: outputs stay quiet
    rst                 = 1'b0;
    bus.mem_read        = 1'b1;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 4'h0;
    bus.mem_address     = 32'h0000_1000;
    bus.mem_wdata       = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_resp",  32'(bus.mem_resp), 32'h0);
      check("rst_rdata", bus.mem_rdata,     32'h0);
      check("rst_err",   32'(bus.mem_err),  32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_1000, 32'h0, lat, rdata, err);
    check("post_rst_latency", 32'(lat), 32'(LAT));
    check("post_rst_rdata",   rdata,    32'h0);
    check("post_rst_err",     32'(err), 32'h1);

    // Directed vector table
    for (int v = 0; v < 17; v++) begin
      @(negedge clk);
      do_req(vecs[v].rd, vecs[v].wr, vecs[v].be, vecs[v].addr, vecs[v].wdata, lat, rdata, err);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(LAT));
      check($sformatf("v%0d_rdata", v),   rdata,    vecs[v].exp_rdata);
      check($sformatf("v%0d_err", v),     32'(err), 32'(vecs[v].exp_err));
    end

    // Read held continuously: accepted every LAT+1 cycles, one pulse each
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_write   = 1'b0;
    bus.mem_address = 32'h0000_0010;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_resp_e%0d", e), 32'(bus.mem_resp), ((e % 4) == 3) ? 32'h1 : 32'h0);
      if ((e % 4) == 3)
        check($sformatf("b2b_rdata_e%0d", e), bus.mem_rdata, 32'hDEAD_12EF);
    end
    bus.mem_read = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_idle", 32'(bus.mem_resp), 32'h0);

    // Write withdrawn after acceptance still completes from the latched request
    @(negedge clk);
    bus.mem_write       = 1'b1;
    bus.mem_read        = 1'b0;
    bus.mem_byte_enable = 4'hF;
    bus.mem_address     = 32'h0000_0000;
    bus.mem_wdata       = 32'h7777_7777;
    @(posedge clk); #1;
    bus.mem_write = 1'b0;
    @(posedge clk); #1;
    check("wd_early", 32'(bus.mem_resp), 32'h0);
    @(posedge clk); #1;
    check("wd_resp", 32'(bus.mem_resp), 32'h1);
    @(posedge clk); #1;
    check("wd_resp_end", 32'(bus.mem_resp), 32'h0);
    @(negedge clk);
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0, lat, rdata, err);
    check("wd_read_latency", 32'(lat), 32'(LAT));
    check("wd_read_rdata",   rdata,    32'h7777_7777);

    // Reset one cycle before a write's resp: no resp, RAM untouched
    @(negedge clk);
    bus.mem_write       = 1'b1;
    bus.mem_byte_enable = 4'hF;
    bus.mem_address     = 32'h0000_0000;
    bus.mem_wdata       = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.mem_write = 1'b0;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      check("rmid_resp_in_rst", 32'(bus.mem_resp), 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      check("rmid_resp_after", 32'(bus.mem_resp), 32'h0);
    end
    @(negedge clk);
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0, lat, rdata, err);
    check("rmid_read_latency", 32'(lat), 32'(LAT));
    check("rmid_read_rdata",   rdata,    32'h7777_7777);
    check("rmid_read_err",     32'(err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
